call_register: RTL and testbench
================================

# call_register

Latches elevator call buttons (hall and cabin, floors A/B/C) into a pending-call register and presents one encoded target floor to the elevator controller on `B1`/`B0`. It is the requesting side of the call interface consumed by the elevator and door state machines: it generates calls, holds them until served, and clears each call when the elevator is stopped at that floor with the door open. Target selection uses a three-state direction machine (collective up/down service). It runs on the 1 Hz system clock in place of the purely combinational call decoder.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per button input. Legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 3: consecutive stable samples required before a press is accepted. Used only when `CALL_DEBOUNCE_EN` is defined.
- `clk`  in  1: system clock (1 Hz domain).
- `reset`  in  1: asynchronous, active-low reset.
- `A_e`, `B_e`, `C_e`  in  1 each: hall call buttons, active-high, asynchronous.
- `A_i`, `B_i`, `C_i`  in  1 each: cabin call buttons, active-high, asynchronous.
- `EA`  in  2: current floor. 00=A, 01=B, 10=C. 11 is illegal and is treated as A.
- `door`  in  1: door state. 1=closed, 0=open.
- `B1`, `B0`  out  1 each: target floor, same encoding as `EA`. 11 means no call.
- `pending`  out  3: latched calls. Bit 0=A, bit 1=B, bit 2=C.
- `dir`  out  2: direction state. 00=IDLE, 01=UP, 10=DOWN.

## Operation
- Each floor's hall and cabin buttons are ORed. The result passes through the synchronizer, then a rising-edge detector. A held button produces exactly one request.
- Request at floor f sets `pending[f]`. A set bit stays set until it is served.
- Serve rule: if `door`=0 and `EA`=f, clear `pending[f]`. A request for floor f arriving while this serve condition holds is dropped, because the floor is being served.
- Clearing takes priority over setting when both occur on the same edge.
- Direction FSM, evaluated every cycle on the registered `pending`:
  - IDLE: no pending bit leaves the FSM in IDLE.
  - IDLE, pending call above the current floor only: go to UP.
  - IDLE, pending call below the current floor only: go to DOWN.
  - IDLE, calls both above and below: go to UP.
  - IDLE, call at the current floor only: stay in IDLE and target the current floor.
  - UP: stay in UP while any call is at or above the current floor. Otherwise go to DOWN if any call exists, else IDLE.
  - DOWN: mirror of UP.
- Target output:
  - UP: nearest pending floor ≥ `EA`.
  - DOWN: nearest pending floor ≤ `EA`.
  - IDLE: current floor if `pending[EA]` is set, else 11.
  - `B1`/`B0` is registered and stays stable until `pending` or `dir` changes.
- The elevator and door machines consume `B1`/`B0` exactly as they consume the decoded calls today.

## Timing
- All outputs are 0 at reset, except `{B1,B0}`=11. All `pending` bits, the synchronizers and the debounce counters clear asynchronously.
- Press to `pending`, without debounce: the bit sets on edge `SYNC_STAGES`+1 after the input rises.
- Press to `pending`, with debounce: add `DEBOUNCE_CYCLES` edges to the above.
- `pending` to `dir`/target: one clock. `dir` and `{B1,B0}` update on the same edge.
- Serve to clear: `pending[f]` clears on the first edge where `door`=0 and `EA`=f. The target moves on the following edge.
- Reset asserted mid-operation: all calls are lost immediately and `dir` returns to IDLE. After reset releases, buttons still held are not re-accepted until they are released and pressed again.
- All three floors pending: calls are served in direction order. No call is starved.

## Configuration
- `CALL_DEBOUNCE_EN` defined: a per-floor saturating counter must see the synchronized level stable high for `DEBOUNCE_CYCLES` samples before the edge detector fires. A release must be stable for the same count before the floor can re-arm.
- `CALL_DEBOUNCE_EN` undefined: there are no counters. The edge detector takes the last synchronizer stage directly.

## Test plan
- Reset held, then released. `pending`=000, `dir`=00 and `{B1,B0}`=11 throughout; toggling buttons during reset has no effect.
- `EA`=00, `door`=1, pulse `C_e`. `pending`=100 at edge 3 and `dir`=01 with `{B1,B0}`=10 at edge 4. Then `EA`=10 and `door`=0: `pending`=000 on the next edge, and `dir`=00 with `{B1,B0}`=11 one edge later.
- `EA`=01, calls A and C pending together. `dir`=UP and target=10. After C is served, `dir`=DOWN and target=00.
- `EA`=01 with `door`=0, press `B_i`. `pending` stays 000.
- Hold `A_i` high for 10 cycles. `pending[0]` sets once. After it is served it does not re-set until `A_i` is released and pressed again.
- With `CALL_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=3: a 2-cycle glitch on `B_e` is ignored, and a 4-cycle press sets `pending[1]`.

Source files
------------

// File: rtl/call_register.sv
// call_register: latches hall/cabin floor calls, clears them when served and drives a collective target floor.
// Define CALL_DEBOUNCE_EN to add per-floor press/release debouncing ahead of the edge detectors.
`default_nettype none

module call_register #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       A_e,
   input  logic       B_e,
   input  logic       C_e,
   input  logic       A_i,
   input  logic       B_i,
   input  logic       C_i,
   input  logic [1:0] EA,
   input  logic       door,
   output logic       B1,
   output logic       B0,
   output logic [2:0] pending,
   output logic [1:0] dir
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } dir_t;

`ifdef CALL_DEBOUNCE_EN
   localparam int WARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
`else
   localparam int WARM_CYCLES = SYNC_STAGES;
`endif
   localparam int WARM_W = $clog2(SYNC_STAGES + DEBOUNCE_CYCLES + 1);

   logic [2:0]        btn;
   logic [2:0]        req;
   logic [2:0]        serve;
   logic [1:0]        floor;
   logic [WARM_W-1:0] warm_cnt;
   logic              warm;
   dir_t              state;
   dir_t              nxt;
   logic [1:0]        target;
   logic [2:0]        above_mask;
   logic [2:0]        below_mask;
   logic              any_above;
   logic              any_below;
   logic              at_floor;

   assign btn   = {C_e | C_i, B_e | B_i, A_e | A_i};
   assign floor = (EA == 2'b11) ? 2'b00 : EA;
   assign serve = door ? 3'b000 : (3'b001 << floor);

   // Edge detection stays disarmed until the input pipeline holds real samples,
   // so a button still held across reset is never taken as a fresh press.
   assign warm = (warm_cnt == WARM_W'(WARM_CYCLES));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         warm_cnt <= '0;
      else if (!warm)
         warm_cnt <= warm_cnt + 1'b1;
   end

   for (genvar f = 0; f < 3; f++) begin : g_floor
      logic [SYNC_STAGES-1:0] sync;
      logic                   level;
      logic                   prev;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            sync <= '0;
         else
            sync <= {sync[SYNC_STAGES-2:0], btn[f]};
      end

`ifdef CALL_DEBOUNCE_EN
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [CW-1:0] cnt;
      logic          stable;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
         end else if (sync[SYNC_STAGES-1] == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync[SYNC_STAGES-1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign level = stable;
`else
      assign level = sync[SYNC_STAGES-1];
`endif

      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            prev <= 1'b1;
         else
            prev <= warm ? level : 1'b1;
      end

      assign req[f] = warm & level & ~prev;
   end

   // A request for the floor being served is dropped: clear wins over set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pending <= 3'b000;
      else
         pending <= (pending | req) & ~serve;
   end

   always_comb begin
      above_mask = 3'b000;
      below_mask = 3'b000;
      case (floor)
         2'd0:    above_mask = 3'b110;
         2'd1: begin
            above_mask = 3'b100;
            below_mask = 3'b001;
         end
         default: below_mask = 3'b011;
      endcase
   end

   assign any_above = |(pending & above_mask);
   assign any_below = |(pending & below_mask);
   assign at_floor  = |(pending & (3'b001 << floor));

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = any_above ? UP : (any_below ? DOWN : IDLE);
         UP:      nxt = (at_floor | any_above) ? UP : ((|pending) ? DOWN : IDLE);
         DOWN:    nxt = (at_floor | any_below) ? DOWN : ((|pending) ? UP : IDLE);
         default: nxt = IDLE;
      endcase
   end

   function automatic logic [1:0] pick(input logic [2:0] p, input logic [1:0] f, input dir_t d);
      logic [1:0] t;
      t = 2'b11;
      case (d)
         UP:   for (int i = 2; i >= 0; i--) if (i >= int'(f) && p[i]) t = 2'(i);
         DOWN: for (int i = 0; i < 3; i++)  if (i <= int'(f) && p[i]) t = 2'(i);
         default: if ((p & (3'b001 << f)) != 3'b000) t = f;
      endcase
      return t;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         target <= 2'b11;
      end else begin
         state  <= nxt;
         target <= pick(pending, floor, nxt);
      end
   end

   assign dir = state;
   assign B1  = target[1];
   assign B0  = target[0];

endmodule

`default_nettype wire

// File: tb/tb_call_register.sv
// tb_call_register: directed stimulus with an edge-indexed scoreboard for call_register.
`default_nettype none

module tb_call_register;

   localparam int SYNC = 2;
   localparam int DEB  = 3;
`ifdef CALL_DEBOUNCE_EN
   localparam int LAT   = SYNC + 1 + DEB;
   localparam int PULSE = DEB + 1;
   localparam int WARM  = SYNC + DEB;
`else
   localparam int LAT   = SYNC + 1;
   localparam int PULSE = 1;
   localparam int WARM  = SYNC;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       A_e, B_e, C_e, A_i, B_i, C_i;
   logic [1:0] EA;
   logic       door;
   logic       B1, B0;
   logic [2:0] pending;
   logic [1:0] dir;

   call_register #(
      .SYNC_STAGES(SYNC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .reset(reset),
      .A_e(A_e), .B_e(B_e), .C_e(C_e),
      .A_i(A_i), .B_i(B_i), .C_i(C_i),
      .EA(EA), .door(door),
      .B1(B1), .B0(B0),
      .pending(pending), .dir(dir)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int         cyc;
      logic [2:0] pend;
      logic [1:0] dr;
      logic [1:0] tgt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected state after edge (cyc + off), kept sorted by edge.
   task automatic push(input int off, input logic [2:0] p, input logic [1:0] d,
                       input logic [1:0] t, input string n);
      exp_t e;
      int   i;
      e.cyc  = cyc + off;
      e.pend = p;
      e.dr   = d;
      e.tgt  = t;
      i = exp_q.size();
      while (i > 0 && exp_q[i-1].cyc > e.cyc) i--;
      exp_q.insert(i, e);
      name_q.insert(i, n);
   endtask

   task automatic check(input string n, input logic [2:0] p, input logic [1:0] d,
                        input logic [1:0] t);
      total++;
      if (pending !== p || dir !== d || {B1, B0} !== t) begin
         bad++;
         $display("FAIL %s at edge %0d: got pending=%b dir=%b target=%b%b, want pending=%b dir=%b target=%b",
                  n, cyc, pending, dir, B1, B0, p, d, t);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t  e;
      string n;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         if (e.cyc != cyc) begin
            total++;
            bad++;
            $display("FAIL %s: expectation for edge %0d missed, now at edge %0d", n, e.cyc, cyc);
         end else begin
            check(n, e.pend, e.dr, e.tgt);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      {A_e, B_e, C_e, A_i, B_i, C_i} = 6'b0;
      EA   = 2'b00;
      door = 1'b1;

      // Reset held while buttons toggle.
      for (int k = 1; k <= 6; k++) push(k, 3'b000, 2'b00, 2'b11, "reset_hold");
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         {A_e, B_e, C_e, A_i, B_i, C_i} = 6'(k * 11);
      end
      {A_e, B_e, C_e, A_i, B_i, C_i} = 6'b0;
      step(1);
      reset = 1'b1;
      for (int k = 1; k <= WARM + 4; k++) push(k, 3'b000, 2'b00, 2'b11, "reset_release");
      step(WARM + 4);

      // Hall call C from floor A, then serve it.
      push(LAT,     3'b100, 2'b00, 2'b11, "hall_c_latch");
      push(LAT + 1, 3'b100, 2'b01, 2'b10, "hall_c_up");
      C_e = 1'b1; step(PULSE); C_e = 1'b0; step(LAT + 1 - PULSE);
      EA = 2'b10; door = 1'b0;
      push(1, 3'b000, 2'b01, 2'b10, "serve_c_clear");
      push(2, 3'b000, 2'b00, 2'b11, "serve_c_idle");
      step(2); door = 1'b1; step(2);

      // Calls A and C from floor B.
      EA = 2'b01;
      push(LAT,     3'b101, 2'b00, 2'b11, "ac_latch");
      push(LAT + 1, 3'b101, 2'b01, 2'b10, "ac_up_to_c");
      A_e = 1'b1; C_i = 1'b1; step(PULSE); A_e = 1'b0; C_i = 1'b0; step(LAT + 1 - PULSE);
      EA = 2'b10; door = 1'b0;
      push(1, 3'b001, 2'b01, 2'b10, "ac_serve_c");
      push(2, 3'b001, 2'b10, 2'b00, "ac_down_to_a");
      step(2); door = 1'b1; EA = 2'b00; step(1);
      door = 1'b0;
      push(1, 3'b000, 2'b10, 2'b00, "ac_serve_a");
      push(2, 3'b000, 2'b00, 2'b11, "ac_idle");
      step(2); door = 1'b1; step(2);

      // Press at the floor being served is dropped.
      EA = 2'b01; door = 1'b0;
      push(LAT,     3'b000, 2'b00, 2'b11, "drop_b_at_serve");
      push(LAT + 3, 3'b000, 2'b00, 2'b11, "drop_b_after_close");
      B_i = 1'b1; step(PULSE); B_i = 1'b0; step(LAT + 1 - PULSE);
      door = 1'b1; step(3);

      // Held cabin A: one request only, re-armed only by release and re-press.
      push(LAT,     3'b001, 2'b00, 2'b11, "hold_a_latch");
      push(LAT + 1, 3'b001, 2'b10, 2'b00, "hold_a_down");
      A_i = 1'b1; step(LAT + 1);
      EA = 2'b00; door = 1'b0;
      push(1, 3'b000, 2'b10, 2'b00, "hold_a_serve");
      push(2, 3'b000, 2'b00, 2'b11, "hold_a_idle");
      step(2); door = 1'b1;
      push(4, 3'b000, 2'b00, 2'b11, "held_no_reaccept");
      step(4); A_i = 1'b0; step(WARM + 4);
      push(LAT,     3'b001, 2'b00, 2'b11, "repress_a_latch");
      push(LAT + 1, 3'b001, 2'b00, 2'b00, "repress_a_at_floor");
      A_i = 1'b1; step(PULSE); A_i = 1'b0; step(LAT + 1 - PULSE);
      door = 1'b0;
      push(1, 3'b000, 2'b00, 2'b00, "repress_a_serve");
      push(2, 3'b000, 2'b00, 2'b11, "repress_a_idle");
      step(2); door = 1'b1; step(2);

      // Illegal floor code 11 behaves as floor A.
      EA = 2'b11;
      push(LAT,     3'b010, 2'b00, 2'b11, "ea11_latch");
      push(LAT + 1, 3'b010, 2'b01, 2'b01, "ea11_up_to_b");
      B_e = 1'b1; step(PULSE); B_e = 1'b0; step(LAT + 1 - PULSE);
      EA = 2'b01; door = 1'b0;
      push(1, 3'b000, 2'b01, 2'b01, "ea11_serve_b");
      push(2, 3'b000, 2'b00, 2'b11, "ea11_idle");
      step(2); door = 1'b1; EA = 2'b00; step(2);

`ifdef CALL_DEBOUNCE_EN
      push(LAT + 2, 3'b000, 2'b00, 2'b11, "glitch_ignored");
      B_e = 1'b1; step(2); B_e = 1'b0; step(LAT + 4);
      push(LAT,     3'b010, 2'b00, 2'b11, "deb_press_latch");
      push(LAT + 1, 3'b010, 2'b01, 2'b01, "deb_press_up");
      B_e = 1'b1; step(4); B_e = 1'b0; step(LAT - 3);
      EA = 2'b01; door = 1'b0; step(2); door = 1'b1; EA = 2'b00; step(DEB + 3);
`endif

      // Reset mid-operation with a button still held.
      push(LAT, 3'b100, 2'b00, 2'b11, "pre_reset_latch");
      C_e = 1'b1; step(LAT);
      #1 reset = 1'b0;
      #1 check("reset_async_clear", 3'b000, 2'b00, 2'b11);
      push(1, 3'b000, 2'b00, 2'b11, "reset_mid_hold");
      step(2);
      reset = 1'b1;
      for (int k = 1; k <= WARM + LAT + 3; k++) push(k, 3'b000, 2'b00, 2'b11, "held_after_reset");
      step(WARM + LAT + 3);
      C_e = 1'b0; step(WARM + 3);
      push(LAT,     3'b100, 2'b00, 2'b11, "c_rearm_latch");
      push(LAT + 1, 3'b100, 2'b01, 2'b10, "c_rearm_up");
      C_e = 1'b1; step(PULSE); C_e = 1'b0; step(LAT + 3 - PULSE);

      while (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL %s: expectation for edge %0d never checked", name_q.pop_front(), exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
